// File: rtl/axil_cmd_master.sv
// Single-beat command/response front end driving an AXI4-Lite master port.
// One transaction in flight; all outputs registered.
module axil_cmd_master #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    cmd_valid,
    output logic                    cmd_ready,
    input  logic                    cmd_write,
    input  logic [ADDR_WIDTH-1:0]   cmd_addr,
    input  logic [DATA_WIDTH-1:0]   cmd_wdata,
    input  logic [DATA_WIDTH/8-1:0] cmd_wstrb,
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic [DATA_WIDTH-1:0]   rsp_rdata,
    output logic [1:0]              rsp_resp,
    output logic                    rsp_write,
    output logic [ADDR_WIDTH-1:0]   AWADDR,
    output logic [2:0]              AWPROT,
    output logic                    AWVALID,
    input  logic                    AWREADY,
    output logic [DATA_WIDTH-1:0]   WDATA,
    output logic [DATA_WIDTH/8-1:0] WSTRB,
    output logic                    WVALID,
    input  logic                    WREADY,
    input  logic [1:0]              BRESP,
    input  logic                    BVALID,
    output logic                    BREADY,
    output logic [ADDR_WIDTH-1:0]   ARADDR,
    output logic [2:0]              ARPROT,
    output logic                    ARVALID,
    input  logic                    ARREADY,
    input  logic [DATA_WIDTH-1:0]   RDATA,
    input  logic [1:0]              RRESP,
    input  logic                    RVALID,
    output logic                    RREADY
);

    typedef enum logic [2:0] {
        IDLE, WRITE, WRESP, READ, RDATA_S, RESP
    } state_t;

    state_t state_q, state_d;
    logic   aw_done, w_done;
    logic   cmd_hs, aw_hs, w_hs, b_hs, ar_hs, r_hs, rsp_hs;
    logic   aw_fin, w_fin;

    assign AWPROT = 3'b000;
    assign ARPROT = 3'b000;

    assign cmd_hs = cmd_valid & cmd_ready;
    assign aw_hs  = AWVALID & AWREADY;
    assign w_hs   = WVALID & WREADY;
    assign b_hs   = BVALID & BREADY;
    assign ar_hs  = ARVALID & ARREADY;
    assign r_hs   = RVALID & RREADY;
    assign rsp_hs = rsp_valid & rsp_ready;

    // AW and W may complete on different cycles; either finishing now or earlier counts.
    assign aw_fin = aw_done | aw_hs;
    assign w_fin  = w_done | w_hs;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // Next-state selection.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (cmd_hs) state_d = cmd_write ? WRITE : READ;
            WRITE:   if (aw_fin && w_fin) state_d = WRESP;
            WRESP:   if (b_hs) state_d = RESP;
            READ:    if (ar_hs) state_d = RDATA_S;
            RDATA_S: if (r_hs) state_d = RESP;
            RESP:    if (rsp_hs) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Registered bus and response outputs, updated on each state's handshake.
    always_ff @(posedge clk) begin
        if (rst) begin
            cmd_ready <= 1'b1;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_resp  <= 2'b00;
            rsp_write <= 1'b0;
            AWADDR    <= '0;
            AWVALID   <= 1'b0;
            WDATA     <= '0;
            WSTRB     <= '0;
            WVALID    <= 1'b0;
            BREADY    <= 1'b0;
            ARADDR    <= '0;
            ARVALID   <= 1'b0;
            RREADY    <= 1'b0;
            aw_done   <= 1'b0;
            w_done    <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (cmd_hs) begin
                        cmd_ready <= 1'b0;
                        aw_done   <= 1'b0;
                        w_done    <= 1'b0;
                        if (cmd_write) begin
                            AWADDR  <= cmd_addr;
                            WDATA   <= cmd_wdata;
                            WSTRB   <= cmd_wstrb;
                            AWVALID <= 1'b1;
                            WVALID  <= 1'b1;
                        end else begin
                            ARADDR  <= cmd_addr;
                            ARVALID <= 1'b1;
                            RREADY  <= 1'b1;
                        end
                    end
                end
                WRITE: begin
                    if (aw_hs) begin
                        AWVALID <= 1'b0;
                        aw_done <= 1'b1;
                    end
                    if (w_hs) begin
                        WVALID <= 1'b0;
                        w_done <= 1'b1;
                    end
                    if (aw_fin && w_fin) BREADY <= 1'b1;
                end
                WRESP: begin
                    if (b_hs) begin
                        BREADY    <= 1'b0;
                        rsp_resp  <= BRESP;
                        rsp_rdata <= '0;
                        rsp_write <= 1'b1;
                        rsp_valid <= 1'b1;
                    end
                end
                READ: begin
                    if (ar_hs) ARVALID <= 1'b0;
                end
                RDATA_S: begin
                    if (r_hs) begin
                        RREADY    <= 1'b0;
                        rsp_rdata <= RDATA;
                        rsp_resp  <= RRESP;
                        rsp_write <= 1'b0;
                        rsp_valid <= 1'b1;
                    end
                end
                RESP: begin
                    if (rsp_hs) begin
                        rsp_valid <= 1'b0;
                        cmd_ready <= 1'b1;
                    end
                end
                default: begin
                    cmd_ready <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_axil_cmd_master.sv
// Bench for axil_cmd_master: table of commands against a small AXI-Lite
// memory slave, scoreboard of expected responses, plus corner sequences.
module tb_axil_cmd_master;

    logic        clk = 1'b0;
    logic        rst;
    logic        cmd_valid, cmd_ready, cmd_write;
    logic [31:0] cmd_addr, cmd_wdata;
    logic [3:0]  cmd_wstrb;
    logic        rsp_valid, rsp_ready, rsp_write;
    logic [31:0] rsp_rdata;
    logic [1:0]  rsp_resp;
    logic [31:0] AWADDR, WDATA, ARADDR, RDATA;
    logic [2:0]  AWPROT, ARPROT;
    logic        AWVALID, AWREADY, WVALID, WREADY;
    logic [3:0]  WSTRB;
    logic [1:0]  BRESP, RRESP;
    logic        BVALID, BREADY, ARVALID, ARREADY, RVALID, RREADY;

    axil_cmd_master #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_write(cmd_write), .cmd_addr(cmd_addr),
        .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_rdata(rsp_rdata), .rsp_resp(rsp_resp),
        .rsp_write(rsp_write),
        .AWADDR(AWADDR), .AWPROT(AWPROT), .AWVALID(AWVALID),
        .AWREADY(AWREADY),
        .WDATA(WDATA), .WSTRB(WSTRB), .WVALID(WVALID), .WREADY(WREADY),
        .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
        .ARADDR(ARADDR), .ARPROT(ARPROT), .ARVALID(ARVALID),
        .ARREADY(ARREADY),
        .RDATA(RDATA), .RRESP(RRESP), .RVALID(RVALID), .RREADY(RREADY)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- AXI-Lite slave model ----------------
    int          wr_wait = 0;
    logic        b_hold = 1'b0;
    logic [31:0] mem [16];
    logic        aw_got, w_got;
    logic [31:0] aw_a, w_d;
    logic [3:0]  w_s;
    int          wcnt;

    wire aw_hs  = AWVALID && AWREADY;
    wire w_hs   = WVALID && WREADY;
    wire aw_now = aw_got || aw_hs;
    wire w_now  = w_got || w_hs;
    wire [31:0] wa_now = aw_got ? aw_a : AWADDR;
    wire [31:0] wd_now = w_got ? w_d : WDATA;
    wire [3:0]  ws_now = w_got ? w_s : WSTRB;

    assign AWREADY = 1'b1;
    assign ARREADY = 1'b1;
    assign WREADY  = (wr_wait == 0) ? 1'b1 : (aw_got && wcnt == 0);

    always @(posedge clk) begin
        if (rst) begin
            aw_got <= 1'b0;
            w_got  <= 1'b0;
            wcnt   <= 0;
            BVALID <= 1'b0;
            BRESP  <= 2'b00;
            RVALID <= 1'b0;
            RDATA  <= '0;
            RRESP  <= 2'b00;
        end else begin
            if (aw_hs) begin
                aw_got <= 1'b1;
                aw_a   <= AWADDR;
                wcnt   <= wr_wait;
            end else if (aw_got && wcnt > 0) begin
                wcnt <= wcnt - 1;
            end
            if (w_hs) begin
                w_got <= 1'b1;
                w_d   <= WDATA;
                w_s   <= WSTRB;
            end
            if (BVALID && BREADY) BVALID <= 1'b0;
            if (aw_now && w_now && !BVALID && !b_hold) begin
                if (wa_now < 32'h40) begin
                    for (int b = 0; b < 4; b++)
                        if (ws_now[b])
                            mem[wa_now[5:2]][8*b +: 8] <= wd_now[8*b +: 8];
                    BRESP <= 2'b00;
                end else begin
                    BRESP <= 2'b10;
                end
                BVALID <= 1'b1;
                aw_got <= 1'b0;
                w_got  <= 1'b0;
            end
            if (ARVALID && ARREADY) begin
                RVALID <= 1'b1;
                RDATA  <= (ARADDR < 32'h40) ? mem[ARADDR[5:2]] : 32'h0;
                RRESP  <= (ARADDR < 32'h40) ? 2'b00 : 2'b10;
            end else if (RVALID && RREADY) begin
                RVALID <= 1'b0;
            end
        end
    end

    initial for (int i = 0; i < 16; i++) mem[i] = 32'h0;

    // ---------------- checking ----------------
    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic        wr;
        logic [31:0] rdata;
        logic [1:0]  resp;
    } exp_t;

    exp_t sb[$];

    int          aw_edge, w_edge, hs_edge;
    int          b_count = 0;
    logic [3:0]  last_wstrb;

    // Monitor: looks just after the falling edge at what the next rising edge will complete.
    always begin
        @(negedge clk);
        #1;
        if (!rst) begin
            if (AWVALID && AWREADY) aw_edge = cyc + 1;
            if (WVALID && WREADY) begin
                w_edge     = cyc + 1;
                last_wstrb = WSTRB;
            end
            if (BVALID && BREADY) b_count++;
            if (rsp_valid && rsp_ready) begin
                hs_edge = cyc + 1;
                if (sb.size() == 0) begin
                    chk("rsp_unexpected", 64'd1, 64'd0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("rsp_write", rsp_write, e.wr);
                    chk("rsp_resp", rsp_resp, e.resp);
                    chk("rsp_rdata", rsp_rdata, e.rdata);
                end
            end
        end
    end

    task automatic drive_cmd(input logic wr, input logic [31:0] addr,
                             input logic [31:0] wd, input logic [3:0] ws,
                             input logic [31:0] erd, input logic [1:0] ers);
        exp_t e;
        e.wr    = wr;
        e.rdata = erd;
        e.resp  = ers;
        sb.push_back(e);
        cmd_write = wr;
        cmd_addr  = addr;
        cmd_wdata = wd;
        cmd_wstrb = ws;
        cmd_valid = 1'b1;
    endtask

    // Caller sits at a falling edge; returns the accepting edge number.
    task automatic wait_accept(output int acc);
        acc = -1;
        for (int n = 0; n < 60; n++) begin
            if (cmd_ready) begin
                @(posedge clk);
                acc = cyc + 1;
                break;
            end
            @(negedge clk);
        end
        if (acc < 0) chk("accept_timeout", 64'd1, 64'd0);
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (sb.size() != 0) chk("drain_timeout", sb.size(), 0);
        @(negedge clk);
    endtask

    typedef struct {
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        logic [31:0] rdata;
        logic [1:0]  resp;
    } vec_t;

    vec_t tv[8];

    initial begin
        #300000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int acc, acc2, b0, stall;
        logic aw_seen, w_seen, bad_aw, bad_w;
        logic stable, cr_bad, v_bad;
        logic [31:0] s_rd;
        logic [1:0]  s_rs;
        logic        s_wr;

        tv[0] = '{1'b1, 32'h0000_0000, 32'hDEAD_BEEF, 4'hF, 32'h0, 2'b00};
        tv[1] = '{1'b0, 32'h0000_0000, 32'h0, 4'h0, 32'hDEAD_BEEF, 2'b00};
        tv[2] = '{1'b1, 32'h0000_0020, 32'h1234_5678, 4'h1, 32'h0, 2'b00};
        tv[3] = '{1'b0, 32'h0000_0020, 32'h0, 4'h0, 32'h0000_0078, 2'b00};
        tv[4] = '{1'b0, 32'hFFFF_FFFC, 32'h0, 4'h0, 32'h0, 2'b10};
        tv[5] = '{1'b1, 32'h0000_0040, 32'h1, 4'hF, 32'h0, 2'b10};
        tv[6] = '{1'b1, 32'h0000_0004, 32'hA5A5_A5A5, 4'hC, 32'h0, 2'b00};
        tv[7] = '{1'b0, 32'h0000_0004, 32'h0, 4'h0, 32'hA5A5_0000, 2'b00};

        rst = 1'b1;
        cmd_valid = 1'b0;
        cmd_write = 1'b0;
        cmd_addr  = '0;
        cmd_wdata = '0;
        cmd_wstrb = '0;
        rsp_ready = 1'b1;
        repeat (3) @(negedge clk);

        chk("rst_cmd_ready", cmd_ready, 1);
        chk("rst_valid_ready",
            {AWVALID, WVALID, ARVALID, BREADY, RREADY, rsp_valid}, 0);
        chk("rst_addr", {AWADDR, ARADDR}, 0);
        chk("rst_wdata_wstrb", {WSTRB, WDATA}, 0);
        chk("rst_rsp", {rsp_write, rsp_resp, rsp_rdata}, 0);
        chk("rst_prot", {AWPROT, ARPROT}, 0);
        rst = 1'b0;
        @(negedge clk);

        // Table: zero-wait slave, latency and bus fields per command.
        for (int i = 0; i < 8; i++) begin
            b0 = b_count;
            drive_cmd(tv[i].wr, tv[i].addr, tv[i].wdata, tv[i].wstrb,
                      tv[i].rdata, tv[i].resp);
            wait_accept(acc);
            wait_drain();
            chk($sformatf("v%0d_rsp_latency", i), hs_edge - acc, 3);
            if (tv[i].wr) begin
                chk($sformatf("v%0d_aw_edge", i), aw_edge - acc, 1);
                chk($sformatf("v%0d_w_edge", i), w_edge - acc, 1);
                chk($sformatf("v%0d_wstrb", i), last_wstrb, tv[i].wstrb);
                chk($sformatf("v%0d_b_count", i), b_count - b0, 1);
            end
        end

        // WREADY held low for 4 cycles after the AW handshake.
        wr_wait = 4;
        b0 = b_count;
        drive_cmd(1'b1, 32'h30, 32'hCAFE_BABE, 4'hF, 32'h0, 2'b00);
        wait_accept(acc);
        aw_seen = 1'b0;
        w_seen  = 1'b0;
        bad_aw  = 1'b0;
        bad_w   = 1'b0;
        stall   = 0;
        for (int n = 0; n < 20 && !w_seen; n++) begin
            if (aw_seen && AWVALID) bad_aw = 1'b1;
            if (!WVALID || WDATA !== 32'hCAFE_BABE) bad_w = 1'b1;
            if (WVALID && WREADY) w_seen = 1'b1;
            else if (aw_seen) stall++;
            if (AWVALID && AWREADY) aw_seen = 1'b1;
            @(negedge clk);
        end
        chk("stall_aw_dropped", bad_aw, 0);
        chk("stall_w_stable", bad_w, 0);
        chk("stall_w_done", w_seen, 1);
        chk("stall_cycles", stall, 4);
        wait_drain();
        chk("stall_one_b", b_count - b0, 1);
        wr_wait = 0;
        drive_cmd(1'b0, 32'h30, 32'h0, 4'h0, 32'hCAFE_BABE, 2'b00);
        wait_accept(acc);
        wait_drain();

        // Response back-pressure with a second command waiting.
        rsp_ready = 1'b0;
        drive_cmd(1'b0, 32'h0, 32'h0, 4'h0, 32'hDEAD_BEEF, 2'b00);
        wait_accept(acc);
        drive_cmd(1'b1, 32'h8, 32'h1122_3344, 4'hF, 32'h0, 2'b00);
        for (int n = 0; n < 20 && !rsp_valid; n++) @(negedge clk);
        chk("bp_rsp_valid", rsp_valid, 1);
        s_rd   = rsp_rdata;
        s_rs   = rsp_resp;
        s_wr   = rsp_write;
        stable = 1'b1;
        cr_bad = 1'b0;
        v_bad  = 1'b0;
        for (int n = 0; n < 10; n++) begin
            if (!rsp_valid || rsp_rdata !== s_rd || rsp_resp !== s_rs ||
                rsp_write !== s_wr) stable = 1'b0;
            if (cmd_ready) cr_bad = 1'b1;
            if (ARVALID || AWVALID || WVALID) v_bad = 1'b1;
            @(negedge clk);
        end
        chk("bp_stable", stable, 1);
        chk("bp_cmd_ready_low", cr_bad, 0);
        chk("bp_no_valid", v_bad, 0);
        rsp_ready = 1'b1;
        wait_accept(acc2);
        chk("bp_accept_after_hs", acc2 - hs_edge, 1);
        wait_drain();

        // Reset while waiting in WRESP.
        b_hold = 1'b1;
        drive_cmd(1'b1, 32'h10, 32'h5555_5555, 4'hF, 32'h0, 2'b00);
        wait_accept(acc);
        for (int n = 0; n < 20 && !BREADY; n++) @(negedge clk);
        chk("mid_bready_up", BREADY, 1);
        rst = 1'b1;
        void'(sb.pop_back());
        @(negedge clk);
        rst = 1'b0;
        b_hold = 1'b0;
        chk("mid_bready_low", BREADY, 0);
        chk("mid_rsp_valid_low", rsp_valid, 0);
        chk("mid_cmd_ready", cmd_ready, 1);
        chk("mid_valids_low", {AWVALID, WVALID, ARVALID, RREADY}, 0);
        @(negedge clk);
        drive_cmd(1'b0, 32'h0, 32'h0, 4'h0, 32'hDEAD_BEEF, 2'b00);
        wait_accept(acc);
        wait_drain();
        chk("post_rst_latency", hs_edge - acc, 3);
        drive_cmd(1'b0, 32'h10, 32'h0, 4'h0, 32'h0, 2'b00);
        wait_accept(acc);
        wait_drain();

        repeat (5) @(negedge clk);
        chk("sb_empty", sb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/axil_cmd_master.md
Name: axil_cmd_master

Overview:
- Bus master stage that sits directly upstream of axilite_slave: it drives the Bus2Master_intf master side.
- Converts a simple single-beat command/response handshake from firmware-side logic (sequencer, debug bridge, test driver) into compliant AXI4-Lite read and write transactions.
- Holds one transaction in flight at a time and returns the read data and response code to the requester.

Parameters:
- ADDR_WIDTH, 32, width of cmd_addr, AWADDR and ARADDR.
- DATA_WIDTH, 32, width of data buses; must be 32 or 64; strobe width is DATA_WIDTH/8.

Ports:
- clk  in  1  single clock for all logic.
- rst  in  1  synchronous, active-high reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  block can accept a command.
- cmd_write  in  1  1 = write, 0 = read.
- cmd_addr  in  ADDR_WIDTH  byte address.
- cmd_wdata  in  DATA_WIDTH  write data.
- cmd_wstrb  in  DATA_WIDTH/8  byte enables.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  requester accepts response.
- rsp_rdata  out  DATA_WIDTH  read data; 0 for writes.
- rsp_resp  out  2  BRESP or RRESP captured from the slave.
- rsp_write  out  1  echoes cmd_write of the completed command.
- AWADDR/AWPROT/AWVALID  out  ADDR_WIDTH/3/1, with AWREADY  in  1.
- WDATA/WSTRB/WVALID  out  DATA_WIDTH/DATA_WIDTH/8/1, with WREADY  in  1.
- BRESP/BVALID  in  2/1, with BREADY  out  1.
- ARADDR/ARPROT/ARVALID  out  ADDR_WIDTH/3/1, with ARREADY  in  1.
- RDATA/RRESP/RVALID  in  DATA_WIDTH/2/1, with RREADY  out  1.

Behaviour:
- All outputs are registered.
- Reset values:
  - State is IDLE and cmd_ready=1.
  - Every VALID and READY output is 0, and rsp_valid=0.
  - All address, data, strobe, rsp_rdata, rsp_resp and rsp_write outputs are 0.
  - *PROT outputs are always 3'b000.
- State machine: IDLE, WRITE, WRESP, READ, RDATA, RESP.
- IDLE:
  - A command is accepted on a cycle where cmd_valid and cmd_ready are both 1.
  - The address, data, strobe and write flag are latched and cmd_ready drops to 0 on the next edge.
  - For a write, the next state is WRITE with AWVALID=1 and WVALID=1 from the cycle after acceptance.
  - For a read, the next state is READ with ARVALID=1 and RREADY=1.
- WRITE:
  - AW and W are independent; each VALID stays high until its own handshake (VALID and READY at a clock edge).
  - Internal flags aw_done and w_done record which handshakes have completed; the two handshakes may land on the same or different cycles, in either order.
  - Once both are done, go to WRESP with BREADY=1.
  - AWADDR, WDATA and WSTRB stay stable while the corresponding VALID is high.
- WRESP:
  - On BVALID with BREADY, capture BRESP, clear BREADY, set rsp_rdata=0 and rsp_write=1, then go to RESP.
- READ:
  - On the ARREADY handshake, clear ARVALID and go to RDATA; RREADY stays 1.
  - If RVALID and RREADY both arrive on the ARREADY cycle, RDATA is not sampled there; it is taken in RDATA.
- RDATA:
  - On RVALID, capture RDATA and RRESP, clear RREADY, set rsp_write=0, then go to RESP.
- RESP:
  - rsp_valid=1 with rsp_rdata, rsp_resp and rsp_write held stable until rsp_ready.
  - On that handshake, clear rsp_valid, set cmd_ready=1 and return to IDLE.
  - Back-to-back throughput is 1 command per (AXI latency + 2) cycles minimum.
- Minimum latency, for a zero-wait slave (cmd accepted at edge N):
  - Write: AW/W handshake at N+1, B handshake at N+2, rsp_valid visible from N+3.
  - Read: AR handshake at N+1, R handshake at N+2, rsp_valid visible from N+3.
- Error responses are passed through unmodified (2'b10 SLVERR, 2'b11 DECERR); the block never generates errors itself.
- Back-pressure: rsp_ready held low keeps the block in RESP indefinitely; cmd_ready stays 0 and no AXI VALID is raised.
- Reset mid-transaction:
  - All VALID and READY outputs drop to 0 on the reset edge and the pending command is discarded.
  - No response is emitted for the discarded command.
  - The slave is reset by the same rst, so no orphan handshake remains.
- cmd_valid while cmd_ready=0 is ignored; the requester must hold the command until it is accepted.

Test Plan:
- Write 0x00000000 / 0xDEADBEEF / strobe 0xF, zero-wait slave -> AW and W handshakes on the same cycle; rsp_valid 3 cycles after accept with rsp_resp=0, rsp_write=1; read-back returns rsp_rdata=0xDEADBEEF, rsp_resp=0.
- Slave holds WREADY low 4 cycles after AWREADY -> AWVALID drops after its handshake; WVALID and WDATA=0xCAFEBABE stay stable until WREADY; exactly one B handshake occurs.
- Write 0x12345678 with strobe 0x1 to 0x20, then read it -> WSTRB=0x1 observed on the bus; rsp_rdata[7:0]=0x78.
- Read 0xFFFFFFFC (out of bounds) -> rsp_resp=2'b10 passed through, rsp_write=0.
- rsp_ready held low for 10 cycles with a second command pending -> rsp outputs stable, cmd_ready=0, no AR/AW VALID during the stall; second command accepted only after the response handshake.
- Assert rst for 1 cycle while in WRESP -> BREADY=0, rsp_valid=0 and cmd_ready=1 on the next cycle; a following read completes normally.
